// File: rtl/imem_load_ctrl_pkg.sv
// Shared types for the instruction-memory load controller: FSM states, the
// NOP filler word and RV32I opcode/encoding helpers used to build programs.
package imem_load_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } imem_ld_state_e;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011
  } opcode_e;

  function automatic logic [31:0] enc_r(input logic [6:0] funct7,
                                        input logic [4:0] rs2,
                                        input logic [4:0] rs1,
                                        input logic [2:0] funct3,
                                        input logic [4:0] rd,
                                        input opcode_e    op);
    return {funct7, rs2, rs1, funct3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm,
                                        input logic [4:0]  rs1,
                                        input logic [2:0]  funct3,
                                        input logic [4:0]  rd,
                                        input opcode_e     op);
    return {imm, rs1, funct3, rd, op};
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Load-stream, memory-port and fetch signals of the instruction-memory
// controller; slave is the controller side, master the surrounding system.
interface imem_load_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic              load_req;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [31:0]       fetch_pc;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_valid;
  logic              fetch_fault;
  logic              cpu_rst_n;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              load_err;

  modport slave (
    input  load_req, s_valid, s_data, s_last, mem_rdata, fetch_pc,
    output s_ready, mem_we, mem_addr, mem_wdata, fetch_instr, fetch_valid,
           fetch_fault, cpu_rst_n, load_done, load_count, load_err
  );

  modport master (
    output load_req, s_valid, s_data, s_last, mem_rdata, fetch_pc,
    input  s_ready, mem_we, mem_addr, mem_wdata, fetch_instr, fetch_valid,
           fetch_fault, cpu_rst_n, load_done, load_count, load_err
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory controller: loads a program stream into the single-port
// memory while holding the core in reset, then serves core fetches from it.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  imem_load_ctrl_if.slave  bus
);

  imem_ld_state_e    r_state;
  imem_ld_state_e    w_next;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_load_count;
  logic              r_load_err;
  logic              r_load_done;
  logic              r_cpu_rst_n;
  logic              r_fetch_valid;
  logic              r_fetch_fault;

  logic              w_s_ready;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_accept;
  logic              w_exit;
  logic              w_pc_bad;
  logic              w_fetch_ok;

  assign w_pc_bad = (bus.fetch_pc[1:0] != 2'b00) || (bus.fetch_pc[31:ADDR_W+2] != '0);

  // A reload request in RUN wins over the fetch issued in the same cycle.
  assign w_fetch_ok = (r_state == RUN) && !bus.load_req;

  always_comb begin
    w_next      = r_state;
    w_s_ready   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_accept    = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.load_req) w_next = LOAD;
      end
      LOAD: begin
        w_s_ready  = 1'b1;
        w_mem_addr = r_wr_ptr;
        if (bus.s_valid) begin
          w_accept    = 1'b1;
          w_mem_we    = 1'b1;
          w_mem_wdata = bus.s_data;
          if (bus.s_last || (r_wr_ptr == '1)) begin
            w_exit = 1'b1;
            w_next = RUN;
          end
        end
      end
      RUN: begin
        w_mem_addr = bus.fetch_pc[ADDR_W+1:2];
        if (bus.load_req) w_next = LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_load_count  <= '0;
      r_load_err    <= 1'b0;
      r_load_done   <= 1'b0;
      r_cpu_rst_n   <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cpu_rst_n   <= (w_next == RUN);
      r_load_done   <= w_exit;
      r_fetch_valid <= w_fetch_ok;
      r_fetch_fault <= w_fetch_ok && w_pc_bad;

      if ((w_next == LOAD) && (r_state != LOAD)) begin
        r_wr_ptr   <= '0;
        r_load_err <= 1'b0;
      end else if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      // An exit without s_last can only come from filling the last word.
      if (w_exit) begin
        r_load_count <= {1'b0, r_wr_ptr} + (ADDR_W+1)'(1);
        if (!bus.s_last) r_load_err <= 1'b1;
      end
    end
  end

  assign bus.s_ready     = w_s_ready;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wdata   = w_mem_wdata;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_fault = r_fetch_fault;
  assign bus.fetch_instr = (r_fetch_valid && !r_fetch_fault) ? bus.mem_rdata
                                                             : DATA_W'(NOP_INSTR);
  assign bus.cpu_rst_n   = r_cpu_rst_n;
  assign bus.load_done   = r_load_done;
  assign bus.load_count  = r_load_count;
  assign bus.load_err    = r_load_err;

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Controller owning the single-port instruction memory that holds encoded RISC-V programs.
- Sequences a program-load phase: accepts a stream of 32-bit instruction words, writes them at consecutive word addresses and holds the core in reset meanwhile.
- After loading, releases the core and serves instruction fetches from the same memory port.
- Substitutes a NOP during any cycle without valid fetch data.

Parameters:
- ADDR_W, 5, word-address width; DEPTH = 2**ADDR_W (32 words).
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_req  in  1  single-cycle pulse requesting a (re)load
- s_valid  in  1  load stream word valid
- s_ready  out  1  load stream word accepted
- s_data  in  DATA_W  instruction word
- s_last  in  1  final word of the program
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data, 1-cycle latency
- fetch_pc  in  32  byte PC from the core
- fetch_instr  out  DATA_W  instruction to the core
- fetch_valid  out  1  fetch_instr corresponds to fetch_pc of the previous cycle
- fetch_fault  out  1  previous-cycle PC misaligned or out of range
- cpu_rst_n  out  1  active-low core reset
- load_done  out  1  one-cycle pulse on load completion
- load_count  out  ADDR_W+1  words written by the last load
- load_err  out  1  sticky: load truncated at DEPTH

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low. All state flops reset asynchronously.
- Reset values:
  - state=IDLE, wr_ptr=0, load_count=0, load_err=0, load_done=0.
  - cpu_rst_n=0, fetch_valid=0, fetch_fault=0, fetch_instr=NOP (0x00000013).
  - s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: core held in reset; load_req -> LOAD.
  - LOAD: s_ready=1 (combinational from state). On s_valid&s_ready in the same cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=s_data, wr_ptr++.
  - LOAD exits to RUN on an accepted word with s_last=1, or on an accepted word with wr_ptr==DEPTH-1. On exit, load_count <= wr_ptr+1.
  - Truncation: if the exit is caused by wr_ptr==DEPTH-1 with s_last=0, load_err <= 1 (sticky until reset or next load_req). Later words are not accepted (s_ready=0).
  - A zero-word load is impossible; s_last on the first word gives load_count=1.
  - load_req during LOAD is ignored.
  - RUN: mem_we=0; mem_addr=fetch_pc[ADDR_W+1:2]. load_req -> LOAD next cycle: cpu_rst_n low, wr_ptr=0, load_err cleared. Memory contents are never cleared.
- cpu_rst_n: registered, high in exactly the cycles where state==RUN, so it rises in the first RUN cycle. load_done pulses in that same cycle.
- Fetch timing (cycle t in RUN, result at t+1):
  - fetch_valid(t+1) = (state(t)==RUN).
  - fetch_fault(t+1) = (state(t)==RUN) & (fetch_pc[1:0]!=0 | fetch_pc[31:ADDR_W+2]!=0).
  - fetch_instr = mem_rdata when fetch_valid & !fetch_fault, else NOP.
- Simultaneous events:
  - load_req in the same cycle as the LOAD->RUN exit is ignored, because LOAD ignores it.
  - load_req in RUN takes priority over the fetch; fetch_valid is 0 in the following cycle.
- Reset mid-operation: any state returns to IDLE with all reset values; a partially written program remains in memory but the core stays in reset.

Decomposition:
- Shared package (alongside the instruction-encoding package):
  - state enum typedef imem_ld_state_e {IDLE, LOAD, RUN}.
  - NOP_INSTR constant 32'h0000_0013.
  - OP_* opcode enum, reused by the bench to build stimulus.
- No sub-module is needed. The memory stays external; the bench supplies a 32x32 synchronous RAM model.

Test Plan:
- Basic load: reset, load_req, then stream 0x002081B3 (add x3,x1,x2), 0x40208233 (sub x4,x1,x2), 0x0020F2B3 (and x5,x1,x2, s_last) -> writes to addresses 0,1,2; load_count=3; load_done and cpu_rst_n high in the cycle after the third handshake.
- Fetch: after the basic load, fetch_pc=0x4 -> next cycle fetch_valid=1, fetch_instr=0x40208233. fetch_pc=0x8 -> 0x0020F2B3.
- Faults:
  - fetch_pc=0x6 (misaligned) -> fetch_fault=1, fetch_instr=0x00000013.
  - fetch_pc=0x80 (out of range) -> same response.
- Overflow and backpressure:
  - Stream 33 words with no s_last -> exactly 32 written; load_err=1; load_count=32; s_ready=0 for word 33.
  - s_valid gaps mid-load -> no writes in gap cycles; wr_ptr holds.
- Reload: load_req in RUN -> cpu_rst_n=0 next cycle, fetch_valid=0. Reload 1 word 0x00000033 with s_last -> load_count=1, load_err cleared; fetch_pc=0 returns 0x00000033.
- Reset mid-load: assert rst_n=0 after 2 of 3 words -> all outputs at reset values immediately. With no load_req afterwards, cpu_rst_n stays 0.
